// File: rtl/mul_arb_pkg.sv
// Shared types and the round-robin grant function for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;

  // Tag id is sized for the largest supported requester count (8).
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [MAX_REQ-1:0] rr_grant(
    input logic [MAX_REQ-1:0] valid,
    input logic [ID_W-1:0]    last,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] grant;
    int                 idx;
    grant = '0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      if (off <= num_req) begin
        idx = (int'(last) + off) % num_req;
        if (grant == '0 && valid[idx]) grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus: per-requester valid/ready, packed operands and one-hot responses.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [2*DATAWIDTH-1:0]       resp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mul_tag_pipe.sv
// Fixed-depth tag shift line; the MSB of each word is its valid bit.
module mul_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DEPTH-1:0] stage_valid
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

  always_comb begin
    stage_valid = '0;
    for (int i = 0; i < DEPTH; i++) stage_valid[i] = stages[i][WIDTH-1];
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external pipelined multiplier among NUM_REQ requesters,
// routing each product back to its issuer through a latency-matched tag line.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int DATAWIDTH   = 4,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mul_share_arbiter_if.slave     req_if,
  output logic                   mul_i_valid,
  output logic [DATAWIDTH-1:0]   mul_A,
  output logic [DATAWIDTH-1:0]   mul_B,
  input  logic                   mul_o_valid,
  input  logic [2*DATAWIDTH-1:0] mul_Z,
  output logic                   busy,
  output logic                   err_seq
);

  logic [ID_W-1:0]        last_grant;
  logic [MAX_REQ-1:0]     valid_ext;
  logic [MAX_REQ-1:0]     grant_ext;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;
  logic                   handshake;
  tag_t                   tag_in;
  tag_t                   tag_out;
  logic [MUL_LATENCY-1:0] stage_valid;
  logic [NUM_REQ-1:0]     resp_valid_q;
  logic [2*DATAWIDTH-1:0] resp_data_q;

  // Grant is suppressed during reset so nothing issues while state is being cleared.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_if.req_valid;
    grant_ext                = rr_grant(valid_ext, last_grant, NUM_REQ);
    grant                    = rst ? '0 : grant_ext[NUM_REQ-1:0];
    handshake                = |grant;
    grant_id                 = '0;
    mul_A                    = '0;
    mul_B                    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        mul_A    = req_if.req_a[i*DATAWIDTH +: DATAWIDTH];
        mul_B    = req_if.req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
    tag_in.valid = handshake;
    tag_in.id    = grant_id;
  end

  assign req_if.req_ready = grant;
  assign mul_i_valid      = handshake;

  always_ff @(posedge clk) begin
    if (rst)            last_grant <= ID_W'(NUM_REQ - 1);
    else if (handshake) last_grant <= grant_id;
  end

  mul_tag_pipe #(
    .DEPTH (MUL_LATENCY),
    .WIDTH ($bits(tag_t))
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .din         (tag_in),
    .dout        (tag_out),
    .stage_valid (stage_valid)
  );

  // Responses follow the tag line alone; a strobe mismatch is only recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_seq      <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (tag_out.valid) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (tag_out.id == ID_W'(i)) resp_valid_q[i] <= 1'b1;
        end
        resp_data_q <= mul_Z;
      end
      if (mul_o_valid != tag_out.valid) err_seq <= 1'b1;
    end
  end

  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign busy              = (|stage_valid) | (|resp_valid_q);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a reference pipelined multiplier and a response scoreboard.
module tb_mul_share_arbiter;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mul_i_valid;
  logic [3:0] mul_A;
  logic [3:0] mul_B;
  logic       mul_o_valid;
  logic [7:0] mul_Z;
  logic       busy;
  logic       err_seq;
  logic       inject;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [3:0] onehot;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mul_share_arbiter_if #(.NUM_REQ(4), .DATAWIDTH(4)) bus ();

  mul_share_arbiter #(
    .DATAWIDTH   (4),
    .NUM_REQ     (4),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (bus),
    .mul_i_valid (mul_i_valid),
    .mul_A       (mul_A),
    .mul_B       (mul_B),
    .mul_o_valid (mul_o_valid),
    .mul_Z       (mul_Z),
    .busy        (busy),
    .err_seq     (err_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference multiplier: LAT-stage pipeline, cleared by reset.
  logic [LAT-1:0] m_v;
  logic [7:0]     m_z [LAT];

  always @(posedge clk) begin
    if (rst) begin
      m_v <= '0;
      for (int i = 0; i < LAT; i++) m_z[i] <= '0;
    end else begin
      m_v[0] <= mul_i_valid;
      m_z[0] <= {4'd0, mul_A} * {4'd0, mul_B};
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1];
        m_z[i] <= m_z[i-1];
      end
    end
  end

  assign mul_o_valid = m_v[LAT-1] | inject;
  assign mul_Z       = m_z[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of requests, checks the combinational grant/issue, and queues the expected response.
  task automatic apply_stimulus(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] exp_ready, input logic [7:0] exp_prod,
                                input bit expect_resp);
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    bus.req_valid = valid;
    bus.req_a     = a;
    bus.req_b     = b;
    exp_a = '0;
    exp_b = '0;
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        exp_a = a[i*4 +: 4];
        exp_b = b[i*4 +: 4];
      end
    end
    @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("mul_i_valid", 32'(mul_i_valid), 32'(|exp_ready));
    check("mul_A", 32'(mul_A), 32'(exp_a));
    check("mul_B", 32'(mul_B), 32'(exp_b));
    if (exp_ready != '0 && expect_resp) sb.push_back('{exp_ready, exp_prod, cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(4'b0000, 16'h0, 16'h0, 4'b0000, 8'd0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    bus.req_valid = '0;
    @(negedge clk);
    check(name, act, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=%b data=%0d, expected no response (cycle %0d)",
                 bus.resp_valid, bus.resp_data, cyc);
      end else begin
        e = sb.pop_front();
        check("resp_valid", 32'(bus.resp_valid), 32'(e.onehot));
        check("resp_data", 32'(bus.resp_data), 32'(e.data));
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    inject        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with requests held high to confirm nothing is granted during reset.
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mul_i_valid", 32'(mul_i_valid), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_seq", 32'(err_seq), 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = '0;

    // Single request: 3*5 from requester 0.
    apply_stimulus(4'b0001, 16'h0003, 16'h0005, 4'b0001, 8'd15, 1'b1);
    check_output("busy_in_flight", 32'(busy), 32'd1);
    idle(3);
    check_output("busy_drained", 32'(busy), 32'd0);

    // All requesting for 8 cycles: a=i+1, b=i+2.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(4'b1111, 16'h4321, 16'h5432, 4'b0001, 8'd2,  1'b1);
      apply_stimulus(4'b1111, 16'h4321, 16'h5432, 4'b0010, 8'd6,  1'b1);
      apply_stimulus(4'b1111, 16'h4321, 16'h5432, 4'b0100, 8'd12, 1'b1);
      apply_stimulus(4'b1111, 16'h4321, 16'h5432, 4'b1000, 8'd20, 1'b1);
    end
    idle(4);

    // Fairness with gaps: r0=9*9, r1=6*7, r3=11*13.
    apply_stimulus(4'b1010, 16'hB069, 16'hD079, 4'b0010, 8'd42,  1'b1);
    apply_stimulus(4'b1010, 16'hB069, 16'hD079, 4'b1000, 8'd143, 1'b1);
    apply_stimulus(4'b1010, 16'hB069, 16'hD079, 4'b0010, 8'd42,  1'b1);
    apply_stimulus(4'b1010, 16'hB069, 16'hD079, 4'b1000, 8'd143, 1'b1);
    apply_stimulus(4'b1011, 16'hB069, 16'hD079, 4'b0001, 8'd81,  1'b1);
    apply_stimulus(4'b1010, 16'hB069, 16'hD079, 4'b0010, 8'd42,  1'b1);
    idle(4);

    // Maximum operands from requester 2.
    apply_stimulus(4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 8'd225, 1'b1);
    idle(4);

    // Reset mid-flight: both pre-reset issues must vanish.
    apply_stimulus(4'b0001, 16'h0003, 16'h0005, 4'b0001, 8'd15, 1'b0);
    apply_stimulus(4'b0001, 16'h0003, 16'h0005, 4'b0001, 8'd15, 1'b0);
    rst = 1'b1;
    apply_stimulus(4'b0001, 16'h0003, 16'h0005, 4'b0000, 8'd0, 1'b0);
    rst = 1'b0;
    check_output("busy_after_reset", 32'(busy), 32'd0);
    apply_stimulus(4'b0011, 16'h0003, 16'h0005, 4'b0001, 8'd15, 1'b1);
    idle(4);
    check_output("err_seq_clean", 32'(err_seq), 32'd0);

    // Strobe with no tag in flight sets the sticky error.
    inject        = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    inject = 1'b0;
    check_output("err_seq_set", 32'(err_seq), 32'd1);
    check_output("err_seq_sticky", 32'(err_seq), 32'd1);
    do_reset();
    check_output("err_seq_cleared", 32'(err_seq), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATAWIDTH, 4, operand width.
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 2, cycles from multiplier i_valid to o_valid (1..8).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is rising-edge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, NUM_REQ, per-requester operation request.
- req_a, in, NUM_REQ*DATAWIDTH, packed A operands; requester i occupies slice i.
- req_b, in, NUM_REQ*DATAWIDTH, packed B operands.
- req_ready, out, NUM_REQ, one-hot grant; a handshake occurs when req_valid[i] & req_ready[i].
- mul_i_valid, out, 1, issue strobe to the shared multiplier.
- mul_A / mul_B, out, DATAWIDTH each, operands to the multiplier.
- mul_o_valid, in, 1, multiplier result strobe.
- mul_Z, in, 2*DATAWIDTH, multiplier product.
- resp_valid, out, NUM_REQ, one-hot result strobe; no backpressure.
- resp_data, out, 2*DATAWIDTH, product shared by all requesters.
- busy, out, 1, at least one operation is in flight.
- err_seq, out, 1, sticky tag/strobe mismatch flag.

Function
REQ-003 Arbitration SHALL be round-robin. The search starts at last_grant+1 modulo NUM_REQ. At most one req_ready bit is set per cycle.
REQ-004 req_ready SHALL be combinational from req_valid and last_grant. req_ready SHALL be 0 for every requester whose req_valid is 0.
REQ-005 On a handshake the block SHALL drive the following combinationally in the same cycle:
- mul_i_valid = 1.
- mul_A = req_a slice of the granted requester.
- mul_B = req_b slice of the granted requester.
REQ-006 When there is no handshake, mul_i_valid SHALL be 0 and mul_A/mul_B SHALL be 0.
REQ-007 last_grant SHALL update to the granted index only on a handshake. It SHALL hold when there is no handshake.
REQ-008 Tag tracking: each handshake SHALL push {valid=1, id} into a MUL_LATENCY-deep tag shift line. A cycle with no handshake SHALL push valid=0. The line SHALL advance every cycle.
REQ-009 When the tag line output is valid, the block SHALL register the response on that cycle's clock edge:
- resp_valid[id] = 1.
- resp_data = mul_Z.
Responses therefore appear MUL_LATENCY+1 cycles after the handshake.
REQ-010 resp_valid SHALL be 0 in all other cycles. resp_data SHALL hold its last value when resp_valid = 0.
REQ-011 The block SHALL sustain back-to-back issue: one handshake every cycle, with results returned in issue order.
REQ-012 busy SHALL be 1 whenever any tag-line stage or the response register holds valid.
REQ-013 If mul_o_valid differs from the tag line output valid in any cycle, err_seq SHALL set to 1 and remain set until rst. Response generation SHALL follow the tag line regardless of err_seq.
REQ-014 If requests arrive on the same cycle that a response is emitted, both SHALL proceed independently with no stall.

Reset
REQ-015 While rst = 1 at a clock edge, the block SHALL:
- clear all tag-line valids;
- clear resp_valid, resp_data, and err_seq;
- set last_grant = NUM_REQ-1, so requester 0 wins first after reset.
REQ-016 rst asserted mid-operation SHALL discard all in-flight tags. No resp_valid SHALL assert for operations issued before reset.
REQ-017 req_ready and mul_i_valid SHALL be 0 during any cycle in which rst = 1.

Structure
REQ-018 A shared package mul_arb_pkg SHALL hold:
- the tag struct {logic valid; logic [$clog2(NUM_REQ)-1:0] id};
- the function that computes the round-robin next grant.
REQ-019 The tag shift line SHALL be a sub-module mul_tag_pipe, parameterised by depth and tag width.
REQ-020 The multiplier SHALL stay external. The top level SHALL connect mul_* ports to the multiplier's i_valid, A, B, o_valid and Z_final.

Verification (NUM_REQ=4, DATAWIDTH=4, MUL_LATENCY=2, reference multiplier attached)
REQ-021 Single request:
- Stimulus: req_valid=0001, a=3, b=5 at cycle 0.
- Response: req_ready=0001 and mul_i_valid=1 at cycle 0; resp_valid=0001 and resp_data=15 at cycle 3.
REQ-022 All requesting:
- Stimulus: req_valid=1111 held for 8 cycles.
- Response: grants 0,1,2,3,0,1,2,3; each resp_valid matches its grant 3 cycles later.
REQ-023 Fairness with gaps:
- Stimulus: requesters 1 and 3 always valid; requester 0 valid at cycle 4 only.
- Response: grants 1,3,1,3,0,1; requester 0 served in cycle 4.
REQ-024 Maximum operands:
- Stimulus: a=15, b=15 from requester 2.
- Response: resp_data=225 with resp_valid=0100.
REQ-025 Reset mid-flight:
- Stimulus: issue at cycles 0–1, rst=1 at cycle 2.
- Response: no resp_valid asserts afterwards; busy=0 at cycle 3; first grant after reset goes to requester 0.
REQ-026 Mismatch:
- Stimulus: force mul_o_valid=1 in a cycle with no tag.
- Response: err_seq=1 from the next cycle until rst.
